proc_param: RTL and testbench

//  Parametrised multicycle processor: 8 GPRs; instruction fetch and load/store over a synchronous memory port.

---
 rtl/proc_param_pkg.sv | 39 +++
 rtl/proc_alu.sv | 29 ++
 rtl/proc_param.sv | 185 ++++++++++++++++++
 tb/tb_proc_param.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_param_pkg.sv
// rtl/proc_param_pkg.sv - opcodes, FSM state encoding and IR field positions for proc_param
package proc_param_pkg;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  localparam int IR_W   = 9;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MWAIT = 3'd2,
    S_EX1   = 3'd3,
    S_EX2   = 3'd4,
    S_EX3   = 3'd5
  } state_t;

  // True for opcodes that take the A -> G -> Rx three-step sequence.
  function automatic logic is_alu_op(input logic [2:0] op);
`ifdef PROC_AND_EN
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
`else
    return (op == OP_ADD) || (op == OP_SUB);
`endif
  endfunction

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational add/sub (and AND when PROC_AND_EN is defined) with zero detect
module proc_alu
  import proc_param_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] g,
  output logic          zero
);

  // Result for the requested op; carry and borrow fall off the top bit.
  always_comb begin
    g = '0;
    case (op)
      OP_ADD:  g = a + b;
      OP_SUB:  g = a - b;
`ifdef PROC_AND_EN
      OP_AND:  g = a & b;
`endif
      default: g = '0;
    endcase
  end

  assign zero = (g == '0);

endmodule

// File: rtl/proc_param.sv
// rtl/proc_param.sv - parametrised multicycle processor, 8 GPRs; PROC_AND_EN enables opcode 7 = AND
module proc_param
  import proc_param_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int MEM_LAT = 1,
  parameter int PC_REG  = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Run,
  input  logic [DW-1:0] DIN,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] DOUT,
  output logic          W,
  output logic          Done,
  output logic [AW-1:0] PC,
  output logic [2:0]    State
);

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
  localparam logic [2:0]    PC_IDX   = 3'(PC_REG);

  logic [DW-1:0]   regs [0:7];
  logic [DW-1:0]   a_reg;
  logic [DW-1:0]   g_reg;
  logic            z_reg;
  logic [IR_W-1:0] ir;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            fetch_wait;

  logic [2:0]    op;
  logic [2:0]    rx_idx;
  logic [2:0]    ry_idx;
  logic [DW-1:0] rx;
  logic [DW-1:0] ry;
  logic [DW-1:0] alu_g;
  logic          alu_z;
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] pc_next;
  logic [DW-1:0] pc_inc;
  logic          last_wait;
  logic          op_nop;
  logic          done_now;
  state_t        done_next;

  assign op        = ir[OP_MSB:OP_LSB];
  assign rx_idx    = ir[X_MSB:X_LSB];
  assign ry_idx    = ir[Y_MSB:Y_LSB];
  assign rx        = regs[rx_idx];
  assign ry        = regs[ry_idx];
  assign pc_cur    = regs[PC_IDX][AW-1:0];
  assign pc_next   = pc_cur + AW'(1);
  // Incremented PC is zero-extended so bits above AW are cleared.
  assign pc_inc    = DW'(pc_next);
  assign last_wait = (cnt == CNT_LAST);
  assign op_nop    = (op == OP_AND) && !is_alu_op(op);
  assign done_next = Run ? S_FETCH : S_IDLE;

  proc_alu #(.DW(DW)) u_alu (
    .op   (op),
    .a    (a_reg),
    .b    (ry),
    .g    (alu_g),
    .zero (alu_z)
  );

  // Done marks the final cycle of the instruction, decoded from the registered state.
  always_comb begin
    done_now = 1'b0;
    case (state)
      S_MWAIT: done_now = !fetch_wait && last_wait;
      S_EX1:   done_now = (op == OP_MV) || (op == OP_MVNZ) || op_nop;
      S_EX2:   done_now = (op == OP_ST);
      S_EX3:   done_now = 1'b1;
      default: done_now = 1'b0;
    endcase
  end

  // Instruction sequencer: fetch, memory wait and per-opcode execute steps.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      a_reg      <= '0;
      g_reg      <= '0;
      z_reg      <= 1'b1;
      ir         <= '0;
      ADDR       <= '0;
      DOUT       <= '0;
      W          <= 1'b0;
      cnt        <= '0;
      fetch_wait <= 1'b0;
      state      <= S_IDLE;
    end else begin
      W <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Run) state <= S_FETCH;
        end
        S_FETCH: begin
          ADDR         <= pc_cur;
          regs[PC_IDX] <= pc_inc;
          cnt          <= '0;
          fetch_wait   <= 1'b1;
          state        <= S_MWAIT;
        end
        S_MWAIT: begin
          if (last_wait) begin
            if (fetch_wait) begin
              ir    <= DIN[IR_W-1:0];
              state <= S_EX1;
            end else begin
              regs[rx_idx] <= DIN;
              state        <= done_next;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EX1: begin
          case (op)
            OP_MV: begin
              regs[rx_idx] <= ry;
              state        <= done_next;
            end
            OP_MVI: begin
              // Immediate word follows the instruction; a later Rx write to PC overrides this increment.
              ADDR         <= pc_cur;
              regs[PC_IDX] <= pc_inc;
              cnt          <= '0;
              fetch_wait   <= 1'b0;
              state        <= S_MWAIT;
            end
            OP_LD: begin
              ADDR       <= ry[AW-1:0];
              cnt        <= '0;
              fetch_wait <= 1'b0;
              state      <= S_MWAIT;
            end
            OP_ST: begin
              ADDR  <= ry[AW-1:0];
              DOUT  <= rx;
              W     <= 1'b1;
              state <= S_EX2;
            end
            OP_MVNZ: begin
              if (!z_reg) regs[rx_idx] <= ry;
              state <= done_next;
            end
            default: begin
              if (is_alu_op(op)) begin
                a_reg <= rx;
                state <= S_EX2;
              end else begin
                state <= done_next;
              end
            end
          endcase
        end
        S_EX2: begin
          if (op == OP_ST) begin
            state <= done_next;
          end else begin
            g_reg <= alu_g;
            z_reg <= alu_z;
            state <= S_EX3;
          end
        end
        S_EX3: begin
          regs[rx_idx] <= g_reg;
          state        <= done_next;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Done  = done_now;
  assign PC    = pc_cur;
  assign State = state;

endmodule

// File: tb/tb_proc_param.sv
// tb/tb_proc_param.sv - scoreboard bench for proc_param (MEM_LAT 1 and 3 instances)
`timescale 1ns/1ps
module tb_proc_param;

  logic        clk;
  logic        reset;
  logic        run;
  logic        run3;
  logic [15:0] din, din3, dout, dout3, addr, addr3, pc, pc3;
  logic        w, w3, done, done3;
  logic [2:0]  state, state3;
  logic [15:0] mem  [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] p1, p2;

  int checks;
  int errors;
  int done_cnt;

  typedef struct {
    string       name;
    int          ridx;
    logic [15:0] val;
    logic [15:0] pcv;
    logic        z;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;

  exp_t exp_q[$];
  st_t  st_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  proc_param #(.DW(16), .AW(16), .MEM_LAT(1), .PC_REG(7)) dut (
    .Clock(clk), .Reset(reset), .Run(run), .DIN(din), .ADDR(addr), .DOUT(dout),
    .W(w), .Done(done), .PC(pc), .State(state)
  );

  proc_param #(.DW(16), .AW(16), .MEM_LAT(3), .PC_REG(7)) dut3 (
    .Clock(clk), .Reset(reset), .Run(run3), .DIN(din3), .ADDR(addr3), .DOUT(dout3),
    .W(w3), .Done(done3), .PC(pc3), .State(state3)
  );

  // One-cycle memory: data for ADDR is on DIN in the cycle after ADDR changes.
  assign din = mem[addr[7:0]];

  // Three-cycle memory: two extra pipeline stages.
  always @(posedge clk) begin
    p1 <= mem3[addr3[7:0]];
    p2 <= p1;
  end
  assign din3 = p2;

  initial begin : store_port
    forever begin
      @(posedge clk);
      if (w) mem[addr[7:0]] = dout;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input int ridx, input logic [15:0] val,
                          input logic [15:0] pcv, input logic z);
    exp_t e;
    e.name = name;
    e.ridx = ridx;
    e.val  = val;
    e.pcv  = pcv;
    e.z    = z;
    exp_q.push_back(e);
  endtask

  task automatic push_st(input logic [15:0] a, input logic [15:0] d);
    st_t s;
    s.a = a;
    s.d = d;
    st_q.push_back(s);
  endtask

  task automatic wait_done_cnt(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_count"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Pops one expected result per Done pulse and checks it after the retiring edge.
  initial begin : done_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !reset) begin
        @(posedge clk);
        #1;
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_reg"}, 32'(dut.regs[e.ridx]), 32'(e.val));
          check({e.name, "_pc"}, 32'(pc), 32'(e.pcv));
          check({e.name, "_z"}, 32'(dut.z_reg), 32'(e.z));
        end
      end
    end
  end

  // Checks address/data of every store and that W stays high exactly one cycle.
  initial begin : store_monitor
    int  w_run;
    st_t s;
    w_run = 0;
    forever begin
      @(negedge clk);
      if (w) begin
        w_run++;
        if (w_run == 1) begin
          if (st_q.size() == 0) begin
            check("unexpected_store", 32'(1), 32'(0));
          end else begin
            s = st_q.pop_front();
            check("st_addr", 32'(addr), 32'(s.a));
            check("st_dout", 32'(dout), 32'(s.d));
          end
        end
      end else if (w_run != 0) begin
        check("w_width", 32'(w_run), 32'(1));
        w_run = 0;
      end
    end
  end

  initial begin : stimulus
    int n;
    logic z7;
    logic [15:0] r1_7;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    reset    = 1'b1;
    run      = 1'b0;
    run3     = 1'b0;
    clear_mem();
    for (int i = 0; i < 256; i++) mem3[i] = 16'h0000;

    // Main program: mvi/add/mvnz/sub/st/ld, then a jump back to 0 via mvi R7 at 0x10.
    mem[0]  = 16'h0048; mem[1]  = 16'h0005;
    mem[2]  = 16'h0048; mem[3]  = 16'hFFFF;
    mem[4]  = 16'h0050; mem[5]  = 16'h0001;
    mem[6]  = 16'h008A;
    mem[7]  = 16'h019A;
    mem[8]  = 16'h00D3;
    mem[9]  = 16'h019A;
    mem[10] = 16'h0048; mem[11] = 16'h1234;
    mem[12] = 16'h0050; mem[13] = 16'h0020;
    mem[14] = 16'h014A;
    mem[15] = 16'h0122;
    mem[16] = 16'h0078; mem[17] = 16'h0000;
    mem3[0] = 16'h0048; mem3[1] = 16'h0005;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'(0));
    check("rst_addr", 32'(addr), 32'(0));
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_w", 32'(w), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_z", 32'(dut.z_reg), 32'(1));
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), 32'(dut.regs[i]), 32'(0));

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_state", 32'(state), 32'(0));
      check("idle_addr", 32'(addr), 32'(0));
      check("idle_w", 32'(w), 32'(0));
      check("idle_done", 32'(done), 32'(0));
    end

    // mvi R1,5 with three-cycle memory: two accesses, two extra cycles each.
    @(negedge clk);
    run3 = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done3) break;
    end
    run3 = 1'b0;
    check("lat3_cycles", 32'(n), 32'(8));
    @(posedge clk);
    #1;
    check("lat3_r1", 32'(dut3.regs[1]), 32'(16'h0005));
    check("lat3_pc", 32'(pc3), 32'(2));
    check("lat3_state", 32'(state3), 32'(0));
    check("lat3_addr", 32'(addr3), 32'(1));
    check("lat3_w", 32'(w3), 32'(0));
    check("lat3_dout", 32'(dout3), 32'(0));

    push_exp("mvi_r1_5",     1, 16'h0005, 16'd2,  1'b1);
    push_exp("mvi_r1_ffff",  1, 16'hFFFF, 16'd4,  1'b1);
    push_exp("mvi_r2_1",     2, 16'h0001, 16'd6,  1'b1);
    push_exp("add_wrap",     1, 16'h0000, 16'd7,  1'b1);
    push_exp("mvnz_z1",      3, 16'h0000, 16'd8,  1'b1);
    push_exp("sub",          2, 16'h0001, 16'd9,  1'b0);
    push_exp("mvnz_z0",      3, 16'h0001, 16'd10, 1'b0);
    push_exp("mvi_r1_1234",  1, 16'h1234, 16'd12, 1'b0);
    push_exp("mvi_r2_20",    2, 16'h0020, 16'd14, 1'b0);
    push_exp("st",           1, 16'h1234, 16'd15, 1'b0);
    push_exp("ld",           4, 16'h1234, 16'd16, 1'b0);
    push_exp("mvi_r7_jump",  7, 16'h0000, 16'd0,  1'b0);
    push_exp("refetch_0",    1, 16'h0005, 16'd2,  1'b0);
    push_st(16'h0020, 16'h1234);

    @(negedge clk);
    run = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("lat1_cycles", 32'(n), 32'(4));
    wait_done_cnt(12, "phase_a");
    run = 1'b0;
    wait_done_cnt(13, "phase_a_end");
    repeat (2) @(posedge clk);
    #1;
    check("a_stop_state", 32'(state), 32'(0));
    check("a_stop_pc", 32'(pc), 32'(2));

    // PC wrap: R7 = 0xFFFF, fetch from 0xFFFF, then mvi immediate comes from address 0.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    clear_mem();
    mem[0]   = 16'h0078;
    mem[1]   = 16'hFFFF;
    mem[255] = 16'h0068;
    push_exp("mvi_r7_ffff", 7, 16'hFFFF, 16'hFFFF, 1'b1);
    push_exp("wrap_mvi_r5", 5, 16'h0078, 16'd1,    1'b1);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    wait_done_cnt(14, "phase_b");
    run = 1'b0;
    wait_done_cnt(15, "phase_b_end");
    @(posedge clk);
    #1;
    check("b_stop_state", 32'(state), 32'(0));

    // Opcode 7, then a store interrupted by reset in its W cycle.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    clear_mem();
    mem[0] = 16'h0048; mem[1] = 16'hF0F0;
    mem[2] = 16'h0050; mem[3] = 16'h0FF0;
    mem[4] = 16'h01CA;
    mem[5] = 16'h0058; mem[6] = 16'h0040;
    mem[7] = 16'h014B;
`ifdef PROC_AND_EN
    r1_7 = 16'h00F0;
    z7   = 1'b0;
`else
    r1_7 = 16'hF0F0;
    z7   = 1'b1;
`endif
    push_exp("mvi_r1_f0f0", 1, 16'hF0F0, 16'd2, 1'b1);
    push_exp("mvi_r2_0ff0", 2, 16'h0FF0, 16'd4, 1'b1);
    push_exp("op7",         1, r1_7,     16'd5, z7);
    push_exp("mvi_r3_40",   3, 16'h0040, 16'd7, z7);
    push_st(16'h0040, r1_7);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    wait_done_cnt(19, "phase_c");
    check("op7_r2_kept", 32'(dut.regs[2]), 32'(16'h0FF0));
    n = 0;
    while (!w && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w_seen", 32'(w), 32'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_w", 32'(w), 32'(0));
    check("abort_state", 32'(state), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_pc", 32'(pc), 32'(0));
    for (int i = 0; i < 8; i++) check($sformatf("abort_r%0d", i), 32'(dut.regs[i]), 32'(0));
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    check("st_q_empty", 32'(st_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
